// File: rtl/axil_pkg.sv
// Shared constants for the AXI-Lite register bridge: response codes and FSM encoding.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_USER = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_USER = 3'd3,
    ST_RD_RESP = 3'd4
  } state_t;

endpackage

// File: rtl/axil_reg_bridge.sv
// AXI4-Lite slave to single-outstanding register strobe bridge for the DTW control block.
// Optional macro AXIL_TIMEOUT_EN: abort a stalled user access after TIMEOUT_CYCLES with SLVERR.
module axil_reg_bridge
  import axil_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_awvalid,
  input  logic [ADDR_WIDTH-1:0] i_awaddr,
  output logic                  o_awready,
  input  logic                  i_wvalid,
  output logic                  o_wready,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic                  o_bvalid,
  input  logic                  i_bready,
  output logic [1:0]            o_bresp,
  input  logic                  i_arvalid,
  output logic                  o_arready,
  input  logic [ADDR_WIDTH-1:0] i_araddr,
  output logic                  o_rvalid,
  input  logic                  i_rready,
  output logic [1:0]            o_rresp,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic [ADDR_WIDTH-1:0] o_reg_address,
  input  logic                  i_reg_invalid_addr,
  output logic                  o_reg_in_rdy,
  input  logic                  i_reg_in_ack_stb,
  output logic [DATA_WIDTH-1:0] o_reg_in_data,
  output logic                  o_reg_out_req,
  input  logic                  i_reg_out_rdy_stb,
  input  logic [DATA_WIDTH-1:0] i_reg_out_data
);

  state_t                  state, state_nxt;
  logic                    armed;
  logic                    aw_done, w_done;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q, rdata_q;
  logic [1:0]              bresp_q, rresp_q;
  logic                    aw_hs, w_hs, ar_hs, aw_got, w_got;
  logic                    tmo_hit;

  // A channel transfers on a rising edge where its valid and ready are both high;
  // valids from the host are never gated by our readies, and our valids hold until taken.
  assign o_awready = (state == ST_IDLE) && armed && !aw_done;
  assign o_wready  = (state == ST_IDLE) && armed && !w_done;
  assign o_arready = (state == ST_IDLE) && armed && !aw_done && !w_done && !i_awvalid;

  assign aw_hs  = i_awvalid && o_awready;
  assign w_hs   = i_wvalid && o_wready;
  assign ar_hs  = i_arvalid && o_arready;
  assign aw_got = aw_done || aw_hs;
  assign w_got  = w_done || w_hs;

`ifdef AXIL_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;

  // Leaving a wait state clears the count, so each access gets the full budget.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt <= '0;
    end else if (state == ST_WR_USER || state == ST_RD_USER) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end else begin
      tmo_cnt <= '0;
    end
  end

  assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (aw_got && w_got) state_nxt = ST_WR_USER;
        else if (ar_hs)      state_nxt = ST_RD_USER;
      end
      ST_WR_USER: if (i_reg_in_ack_stb || tmo_hit)  state_nxt = ST_WR_RESP;
      ST_WR_RESP: if (i_bready)                     state_nxt = ST_IDLE;
      ST_RD_USER: if (i_reg_out_rdy_stb || tmo_hit) state_nxt = ST_RD_RESP;
      ST_RD_RESP: if (i_rready)                     state_nxt = ST_IDLE;
      default:                                      state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed   <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      bresp_q <= RESP_OKAY;
      rresp_q <= RESP_OKAY;
    end else begin
      armed <= 1'b1;
      if (aw_hs) addr_q  <= i_awaddr;
      if (ar_hs) addr_q  <= i_araddr;
      if (w_hs)  wdata_q <= i_wdata;
      // Capture flags persist until the pair is complete, even across an interleaved read.
      if (aw_got && w_got) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        aw_done <= aw_got;
        w_done  <= w_got;
      end
      if (state == ST_WR_USER) begin
        if (i_reg_in_ack_stb) bresp_q <= i_reg_invalid_addr ? RESP_SLVERR : RESP_OKAY;
        else if (tmo_hit)     bresp_q <= RESP_SLVERR;
      end
      if (state == ST_RD_USER) begin
        if (i_reg_out_rdy_stb) begin
          rresp_q <= i_reg_invalid_addr ? RESP_SLVERR : RESP_OKAY;
          rdata_q <= i_reg_invalid_addr ? '0 : i_reg_out_data;
        end else if (tmo_hit) begin
          rresp_q <= RESP_SLVERR;
          rdata_q <= '0;
        end
      end
    end
  end

  assign o_reg_in_rdy  = (state == ST_WR_USER);
  assign o_reg_out_req = (state == ST_RD_USER);
  assign o_reg_address = addr_q;
  assign o_reg_in_data = wdata_q;
  assign o_bvalid      = (state == ST_WR_RESP);
  assign o_bresp       = o_bvalid ? bresp_q : RESP_OKAY;
  assign o_rvalid      = (state == ST_RD_RESP);
  assign o_rresp       = o_rvalid ? rresp_q : RESP_OKAY;
  assign o_rdata       = o_rvalid ? rdata_q : '0;

endmodule

// File: tb/tb_axil_reg_bridge.sv
// Self-checking bench for axil_reg_bridge: vector table plus hand sequences for ordering and reset.
module tb_axil_reg_bridge;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_awvalid = 1'b0, i_wvalid = 1'b0, i_bready = 1'b0;
  logic        i_arvalid = 1'b0, i_rready = 1'b0;
  logic [15:0] i_awaddr = '0, i_araddr = '0;
  logic [31:0] i_wdata = '0, i_reg_out_data = '0;
  logic        i_reg_invalid_addr = 1'b0, i_reg_in_ack_stb = 1'b0, i_reg_out_rdy_stb = 1'b0;
  logic        o_awready, o_wready, o_bvalid, o_arready, o_rvalid;
  logic        o_reg_in_rdy, o_reg_out_req;
  logic [1:0]  o_bresp, o_rresp;
  logic [31:0] o_rdata, o_reg_in_data;
  logic [15:0] o_reg_address;

  axil_reg_bridge dut (
    .clk(clk), .rst(rst),
    .i_awvalid(i_awvalid), .i_awaddr(i_awaddr), .o_awready(o_awready),
    .i_wvalid(i_wvalid), .o_wready(o_wready), .i_wdata(i_wdata),
    .o_bvalid(o_bvalid), .i_bready(i_bready), .o_bresp(o_bresp),
    .i_arvalid(i_arvalid), .o_arready(o_arready), .i_araddr(i_araddr),
    .o_rvalid(o_rvalid), .i_rready(i_rready), .o_rresp(o_rresp), .o_rdata(o_rdata),
    .o_reg_address(o_reg_address), .i_reg_invalid_addr(i_reg_invalid_addr),
    .o_reg_in_rdy(o_reg_in_rdy), .i_reg_in_ack_stb(i_reg_in_ack_stb),
    .o_reg_in_data(o_reg_in_data), .o_reg_out_req(o_reg_out_req),
    .i_reg_out_rdy_stb(i_reg_out_rdy_stb), .i_reg_out_data(i_reg_out_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [33:0] exp_q[$];

  typedef struct {
    logic        is_wr;
    logic [15:0] addr;
    logic [31:0] data;
    logic        inv;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic sb_pop(output logic [33:0] e);
    if (exp_q.size() == 0) begin
      check("sb_underflow", 64'd1, 64'd0);
      e = '0;
    end else begin
      e = exp_q.pop_front();
    end
  endtask

  task automatic write_user_phase(input logic [15:0] ea, input logic [31:0] ed, input logic inv,
                                  input int ack_dly, input int b_dly, input logic [1:0] er);
    int n;
    logic [1:0] resp_now;
    logic [33:0] e;
    n = 0;
    while (!o_reg_in_rdy && n < 50) begin step(); n++; end
    check("wr_in_rdy", o_reg_in_rdy, 1);
    check("wr_addr", o_reg_address, ea);
    check("wr_data", o_reg_in_data, ed);
    check("wr_no_rd_req", o_reg_out_req, 0);
    repeat (ack_dly) begin step(); check("wr_rdy_hold", o_reg_in_rdy, 1); end
    i_reg_in_ack_stb = 1'b1;
    i_reg_invalid_addr = inv;
    exp_q.push_back({er, 32'h0});
    step();
    i_reg_in_ack_stb = 1'b0;
    i_reg_invalid_addr = 1'b0;
    check("wr_rdy_drop", o_reg_in_rdy, 0);
    check("bvalid_rise", o_bvalid, 1);
    repeat (b_dly) begin
      step();
      check("bvalid_hold", o_bvalid, 1);
      check("bresp_hold", o_bresp, er);
    end
    resp_now = o_bresp;
    i_bready = 1'b1;
    step();
    i_bready = 1'b0;
    sb_pop(e);
    check("bresp", resp_now, e[33:32]);
    check("bvalid_fall", o_bvalid, 0);
  endtask

  task automatic do_write(input logic [15:0] a, input logic [31:0] d, input logic inv,
                          input int ack_dly, input int b_dly, input logic [1:0] er);
    int n;
    logic aw_f, w_f;
    i_awvalid = 1'b1; i_awaddr = a;
    i_wvalid  = 1'b1; i_wdata  = d;
    #1;
    n = 0;
    while ((i_awvalid || i_wvalid) && n < 50) begin
      aw_f = i_awvalid && o_awready;
      w_f  = i_wvalid && o_wready;
      step();
      if (aw_f) i_awvalid = 1'b0;
      if (w_f)  i_wvalid  = 1'b0;
      n++;
    end
    check("aw_w_accept", {i_awvalid, i_wvalid}, 0);
    i_awvalid = 1'b0;
    i_wvalid  = 1'b0;
    write_user_phase(a, d, inv, ack_dly, b_dly, er);
  endtask

  task automatic do_read(input logic [15:0] a, input logic [31:0] ud, input logic inv,
                         input int ack_dly, input int r_dly, input logic [1:0] er,
                         input logic [31:0] edata);
    int n;
    logic f;
    logic [1:0] resp_now;
    logic [31:0] data_now;
    logic [33:0] e;
    i_arvalid = 1'b1; i_araddr = a;
    #1;
    n = 0;
    while (i_arvalid && n < 50) begin
      f = o_arready;
      step();
      if (f) i_arvalid = 1'b0;
      n++;
    end
    check("ar_accept", i_arvalid, 0);
    i_arvalid = 1'b0;
    n = 0;
    while (!o_reg_out_req && n < 50) begin step(); n++; end
    check("rd_req", o_reg_out_req, 1);
    check("rd_addr", o_reg_address, a);
    repeat (ack_dly) begin step(); check("rd_req_hold", o_reg_out_req, 1); end
    i_reg_out_rdy_stb = 1'b1;
    i_reg_out_data = ud;
    i_reg_invalid_addr = inv;
    exp_q.push_back({er, edata});
    step();
    i_reg_out_rdy_stb = 1'b0;
    i_reg_out_data = 32'hffff_ffff;
    i_reg_invalid_addr = 1'b0;
    check("rd_req_drop", o_reg_out_req, 0);
    check("rvalid_rise", o_rvalid, 1);
    repeat (r_dly) begin
      step();
      check("rvalid_hold", o_rvalid, 1);
      check("rdata_hold", o_rdata, edata);
    end
    resp_now = o_rresp;
    data_now = o_rdata;
    i_rready = 1'b1;
    step();
    i_rready = 1'b0;
    sb_pop(e);
    check("rresp", resp_now, e[33:32]);
    check("rdata", data_now, e[31:0]);
    check("rvalid_fall", o_rvalid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b1, 16'h0008, 32'h0000_0040, 1'b0, OKAY,   32'h0};
    vecs[1] = '{1'b0, 16'h0010, 32'h0ca7_cafe, 1'b0, OKAY,   32'h0ca7_cafe};
    vecs[2] = '{1'b0, 16'h0020, 32'hdead_beef, 1'b1, SLVERR, 32'h0};
    vecs[3] = '{1'b1, 16'h0020, 32'h0000_1234, 1'b1, SLVERR, 32'h0};
    vecs[4] = '{1'b1, 16'hfffc, 32'hffff_ffff, 1'b0, OKAY,   32'h0};
    vecs[5] = '{1'b0, 16'h0004, 32'h5a5a_a5a5, 1'b0, OKAY,   32'h5a5a_a5a5};

    // Reset state
    repeat (3) step();
    check("rst_awready", o_awready, 0);
    check("rst_wready", o_wready, 0);
    check("rst_arready", o_arready, 0);
    check("rst_bvalid", o_bvalid, 0);
    check("rst_rvalid", o_rvalid, 0);
    check("rst_in_rdy", o_reg_in_rdy, 0);
    check("rst_out_req", o_reg_out_req, 0);
    check("rst_address", o_reg_address, 0);
    check("rst_in_data", o_reg_in_data, 0);
    rst = 1'b1;
    step();

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].is_wr)
        do_write(vecs[i].addr, vecs[i].data, vecs[i].inv,
                 $urandom_range(0, 3), $urandom_range(0, 3), vecs[i].exp_resp);
      else
        do_read(vecs[i].addr, vecs[i].data, vecs[i].inv,
                $urandom_range(0, 3), $urandom_range(0, 3), vecs[i].exp_resp, vecs[i].exp_rdata);
    end

    // W three cycles ahead of AW: one user write, only once both are in
    i_wvalid = 1'b1; i_wdata = 32'h0000_0077;
    step();
    i_wvalid = 1'b0;
    check("w_first_wready_low", o_wready, 0);
    repeat (2) begin
      step();
      check("w_first_no_req", o_reg_in_rdy, 0);
      check("w_first_awready", o_awready, 1);
    end
    i_awvalid = 1'b1; i_awaddr = 16'h000c;
    step();
    i_awvalid = 1'b0;
    write_user_phase(16'h000c, 32'h0000_0077, 1'b0, 1, 0, OKAY);
    repeat (2) begin step(); check("w_first_single", o_reg_in_rdy, 0); end

    // Strobes in IDLE are ignored
    i_reg_in_ack_stb = 1'b1; i_reg_out_rdy_stb = 1'b1; i_reg_invalid_addr = 1'b1;
    step();
    i_reg_in_ack_stb = 1'b0; i_reg_out_rdy_stb = 1'b0; i_reg_invalid_addr = 1'b0;
    step();
    check("stray_bvalid", o_bvalid, 0);
    check("stray_rvalid", o_rvalid, 0);

    // AW and AR together: write first, bready held low for 5 cycles, then the read
    i_arvalid = 1'b1; i_araddr = 16'h0030;
    i_awvalid = 1'b1; i_awaddr = 16'h0024;
    #1;
    check("ar_blocked", o_arready, 0);
    do_write(16'h0024, 32'h0000_a5a5, 1'b0, 1, 5, OKAY);
    check("ar_still_pending", i_arvalid, 1);
    check("ar_no_req_yet", o_reg_out_req, 0);
    do_read(16'h0030, 32'h1122_3344, 1'b0, 0, 2, OKAY, 32'h1122_3344);

    // Reset during RD_USER aborts with no response
    i_arvalid = 1'b1; i_araddr = 16'h0040;
    step();
    i_arvalid = 1'b0;
    step();
    check("pre_rst_req", o_reg_out_req, 1);
    rst = 1'b0;
    #1;
    check("midrst_out_req", o_reg_out_req, 0);
    check("midrst_address", o_reg_address, 0);
    check("midrst_rvalid", o_rvalid, 0);
    check("midrst_arready", o_arready, 0);
    check("midrst_awready", o_awready, 0);
    step();
    rst = 1'b1;
    step();
    check("post_rst_rvalid", o_rvalid, 0);
    do_read(16'h0044, 32'h1357_2468, 1'b0, 2, 1, OKAY, 32'h1357_2468);

    check("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axil_reg_bridge.md
Name: axil_reg_bridge

Overview:
AXI4-Lite slave that converts AXI-Lite register accesses into a simple single-outstanding register strobe interface for the accelerator control block. Sits between the host AXI-Lite interconnect and the control/status register file of the DTW accelerator. One transaction (read or write) is in flight at a time. The user side acknowledges with single-cycle strobes and flags invalid addresses, which are reported as SLVERR.

Parameters:
ADDR_WIDTH, 16, AXI and register address width
DATA_WIDTH, 32, AXI and register data width
TIMEOUT_CYCLES, 256, user-ack timeout (used only with AXIL_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
i_awvalid  in  1  write address valid
i_awaddr  in  ADDR_WIDTH  write address
o_awready  out  1  write address ready
i_wvalid  in  1  write data valid
o_wready  out  1  write data ready
i_wdata  in  DATA_WIDTH  write data (full word, no strobes)
o_bvalid  out  1  write response valid
i_bready  in  1  write response ready
o_bresp  out  2  00 OKAY, 10 SLVERR
i_arvalid  in  1  read address valid
o_arready  out  1  read address ready
i_araddr  in  ADDR_WIDTH  read address
o_rvalid  out  1  read data valid
i_rready  in  1  read data ready
o_rresp  out  2  00 OKAY, 10 SLVERR
o_rdata  out  DATA_WIDTH  read data
o_reg_address  out  ADDR_WIDTH  latched address of current access
i_reg_invalid_addr  in  1  user flags bad address; sampled with ack/rdy strobe
o_reg_in_rdy  out  1  write data pending for user (level)
i_reg_in_ack_stb  in  1  user consumed write (1-cycle)
o_reg_in_data  out  DATA_WIDTH  latched write data
o_reg_out_req  out  1  read request pending for user (level)
i_reg_out_rdy_stb  in  1  user read data valid (1-cycle)
i_reg_out_data  in  DATA_WIDTH  user read data

Behaviour:
- Reset (rst low, async): all outputs 0; state IDLE; latched address/data/resp 0.
- States: IDLE, WR_USER, WR_RESP, RD_USER, RD_RESP.
- IDLE: o_awready and o_wready are 1 until their channel is captured; AW and W are captured independently (either order, same cycle allowed), each flag held until both are captured. o_arready is 1 only in IDLE with no AW/W captured and i_awvalid low (write priority on simultaneous AW/AR).
- Both AW and W captured at cycle N -> cycle N+1: WR_USER, o_reg_in_rdy=1, o_reg_address=awaddr, o_reg_in_data=wdata; readies 0.
- WR_USER: i_reg_in_ack_stb at cycle M -> o_reg_in_rdy=0, o_bvalid=1, o_bresp = i_reg_invalid_addr at M ? 10 : 00, all from M+1 (WR_RESP).
- WR_RESP: o_bvalid and o_bresp held until i_bready; next cycle IDLE.
- AR handshake at cycle N -> N+1: RD_USER, o_reg_out_req=1, o_reg_address=araddr.
- RD_USER: i_reg_out_rdy_stb at M -> from M+1 o_reg_out_req=0, o_rvalid=1, o_rdata=i_reg_out_data at M, o_rresp = invalid ? 10 : 00 (RD_RESP).
- RD_RESP: o_rvalid/o_rdata/o_rresp stable until i_rready; next cycle IDLE.
- Strobes outside the matching wait state are ignored. Ack and invalid strobe in the same cycle is legal and expected.
- Reset mid-transaction aborts it immediately; no response is issued.

Optional Feature:
AXIL_TIMEOUT_EN: when defined, a counter runs in WR_USER/RD_USER; after TIMEOUT_CYCLES cycles without the strobe the request is dropped (in_rdy/out_req to 0) and the response completes with SLVERR (rdata 0). When not defined, the block waits indefinitely.

Decomposition:
- Package axil_pkg: RESP_OKAY=2'b00, RESP_SLVERR=2'b10, state encoding for the five states.
- No sub-module; single flat FSM with capture flags and response registers.

Test Plan:
- AW 0x0008 + W 0x00000040 same cycle -> o_reg_in_rdy=1, o_reg_address=0x0008, data 0x00000040; ack with invalid=0 -> bvalid next cycle, bresp=00.
- W before AW (W at t, AW at t+3) -> single user write issued after AW captured; bresp=00.
- AR 0x0010; user replies 0x0ca7cafe on rdy_stb -> o_rvalid=1, o_rdata=0x0ca7cafe, rresp=00.
- Read 0x0020 with invalid=1 alongside rdy_stb -> rresp=10, rdata=0; write to 0x0020 with invalid -> bresp=10.
- AW and AR valid same cycle -> write completes first, then read is accepted; bready held low 5 cycles -> bvalid/bresp stable for the duration.
- rst low during RD_USER -> all outputs 0 immediately; after release, new read completes normally.
